// File: rtl/imem_pkg.sv
// Shared constants, state encoding and fetch-target check for the CPU31 instruction fetch path.
package imem_pkg;

  localparam logic [31:0] IMEM_BASE_DFLT = 32'h0040_0000;
  localparam int          IMEM_AW_DFLT   = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // 33-bit limit so a window ending at 2^32 cannot wrap to a small value.
  function automatic logic pc_valid(input logic [31:0] pc, input logic [31:0] base,
                                    input int aw);
    logic [32:0] lim;
    lim = {1'b0, base} + (33'd4 << aw);
    return (pc[1:0] == 2'b00) && (pc >= base) && ({1'b0, pc} < lim);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo
  import imem_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output logic [CW-1:0] count_o,
  output logic         head_valid_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      // Push into a full FIFO only happens alongside a pop, so the slot is the one leaving.
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign count_o      = cnt_q;
  assign head_valid_o = (cnt_q != '0);
  assign head_o       = mem_q[rd_q];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: fetch PC, ROM address, push gating, redirect/fault FSM.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE = IMEM_BASE_DFLT,
  parameter int          IMEM_AW   = IMEM_AW_DFLT,
  parameter int          DEPTH     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] im_addr,
  input  logic [31:0]        im_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr,
  output logic               fault
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count;
  logic          pc_ok, redir_ok, push, pop;
  fetch_entry_t  head, wentry;

  assign pc_ok    = pc_valid(pc_q, IMEM_BASE, IMEM_AW);
  assign redir_ok = pc_valid(redirect_pc, IMEM_BASE, IMEM_AW);

  // A redirect suppresses the handshake entirely; the flush wins.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = (state_q == ST_RUN) & ~redirect_valid & pc_ok &
                ((count < CW'(DEPTH)) | pop);

  assign wentry = '{pc: pc_q, instr: im_instr};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (!redir_ok)     state_d = ST_FAULT;
      else if (fetch_en) state_d = ST_RUN;
      else               state_d = ST_IDLE;
    end else begin
      if (push) pc_d = pc_q + 32'd4;
      case (state_q)
        ST_IDLE: if (fetch_en) state_d = ST_RUN;
        ST_RUN: begin
          if (!pc_ok)         state_d = ST_FAULT;
          else if (!fetch_en) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= IMEM_BASE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .wdata_i      (wentry),
    .count_o      (count),
    .head_valid_o (out_valid),
    .head_o       (head)
  );

  // Out-of-window PCs still produce a (truncated) address; the ROM read is just ignored.
  assign im_addr   = IMEM_AW'((pc_q - IMEM_BASE) >> 2);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign fault     = (state_q == ST_FAULT);

endmodule
